// File: rtl/slot_bitmap_writer_if.sv
// ----------------------------------------------------------------------------
// slot_bitmap_writer_if : set/clear command channels and occupancy status bus
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface slot_bitmap_writer_if #(
   parameter int WIDTH     = 32,
   parameter int LOG_WIDTH = 5
);
   logic                 set_valid;
   logic [LOG_WIDTH-1:0] set_idx;
   logic                 set_ready;
   logic                 clr_valid;
   logic [LOG_WIDTH-1:0] clr_idx;
   logic                 clr_ready;
   logic [WIDTH-1:0]     bitmap;
   logic [LOG_WIDTH:0]   count;
   logic                 full;
   logic                 empty;
   logic                 err_dup_set;
   logic                 err_bad_clr;
   logic                 err_range;

   modport master (
      output set_valid, set_idx, clr_valid, clr_idx,
      input  set_ready, clr_ready, bitmap, count, full, empty,
             err_dup_set, err_bad_clr, err_range
   );

   modport slave (
      input  set_valid, set_idx, clr_valid, clr_idx,
      output set_ready, clr_ready, bitmap, count, full, empty,
             err_dup_set, err_bad_clr, err_range
   );
endinterface

`default_nettype wire

// File: rtl/slot_bitmap_writer.sv
// ----------------------------------------------------------------------------
// slot_bitmap_writer : registered slot occupancy bitmap with set/clear channels,
//                      incremental popcount, full/empty and protocol error pulses
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module slot_bitmap_writer #(
   parameter int WIDTH     = 32,
   parameter int LOG_WIDTH = 5
) (
   input  wire                 clk,
   input  wire                 rst,
   slot_bitmap_writer_if.slave bus
);

   localparam logic [LOG_WIDTH:0] c_WIDTH   = (LOG_WIDTH+1)'(WIDTH);
   localparam logic [LOG_WIDTH:0] c_CNT_ONE = (LOG_WIDTH+1)'(1);
   localparam logic [WIDTH-1:0]   c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]   bitmap_q, bitmap_d;
   logic [LOG_WIDTH:0] count_q, count_d;
   logic               full_q, full_d;
   logic               empty_q, empty_d;
   logic               err_dup_q, err_dup_d;
   logic               err_clr_q, err_clr_d;
   logic               err_rng_q, err_rng_d;

   logic               w_set_fire, w_clr_fire;
   logic               w_set_inr, w_clr_inr;
   logic [WIDTH-1:0]   w_set_mask, w_clr_mask, w_after_clr;
   logic               w_set_apply, w_clr_apply;

   // Readiness depends only on registered state, never on the valids.
   assign w_set_fire = bus.set_valid && !full_q;
   assign w_clr_fire = bus.clr_valid && !empty_q;

   assign w_set_inr  = {1'b0, bus.set_idx} < c_WIDTH;
   assign w_clr_inr  = {1'b0, bus.clr_idx} < c_WIDTH;
   assign w_set_mask = (w_set_fire && w_set_inr) ? (c_ONE << bus.set_idx) : '0;
   assign w_clr_mask = (w_clr_fire && w_clr_inr) ? (c_ONE << bus.clr_idx) : '0;

   // Clear resolves first; the set then sees the post-clear value.
   assign w_clr_apply = |(bitmap_q & w_clr_mask);
   assign w_after_clr = bitmap_q & ~w_clr_mask;
   assign w_set_apply = (|w_set_mask) && !(|(w_after_clr & w_set_mask));

   always_comb begin
      bitmap_d  = w_after_clr | w_set_mask;
      count_d   = count_q;
      err_dup_d = w_set_fire && w_set_inr && !w_set_apply;
      err_clr_d = w_clr_fire && w_clr_inr && !w_clr_apply;
      err_rng_d = (w_set_fire && !w_set_inr) || (w_clr_fire && !w_clr_inr);
      case ({w_set_apply, w_clr_apply})
         2'b10:   count_d = count_q + c_CNT_ONE;
         2'b01:   count_d = count_q - c_CNT_ONE;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == c_WIDTH);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bitmap_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         err_dup_q <= 1'b0;
         err_clr_q <= 1'b0;
         err_rng_q <= 1'b0;
      end else begin
         bitmap_q  <= bitmap_d;
         count_q   <= count_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         err_dup_q <= err_dup_d;
         err_clr_q <= err_clr_d;
         err_rng_q <= err_rng_d;
      end
   end

   assign bus.set_ready   = !full_q;
   assign bus.clr_ready   = !empty_q;
   assign bus.bitmap      = bitmap_q;
   assign bus.count       = count_q;
   assign bus.full        = full_q;
   assign bus.empty       = empty_q;
   assign bus.err_dup_set = err_dup_q;
   assign bus.err_bad_clr = err_clr_q;
   assign bus.err_range   = err_rng_q;

endmodule

`default_nettype wire

// File: doc/slot_bitmap_writer.md
# slot_bitmap_writer

Write-side companion to the scheduler's lowest-index priority encoder. It owns a `width`-bit slot occupancy bitmap, which is the vector the encoder scans. The block accepts binary slot indices on independent set and clear command channels. It decodes each index to one-hot and updates the registered bitmap. It also maintains occupancy count and full/empty flags, and flags protocol errors (duplicate set, clear of an empty slot, out-of-range index).

## Interface
Parameters:
- `width`, 32, number of slots (bitmap width); need not be a power of two
- `log_width`, 5, index width; `2**log_width >= width`

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `set_valid`  in  1  set command present
- `set_idx`  in  log_width  slot to mark occupied
- `set_ready`  out  1  set channel can accept
- `clr_valid`  in  1  clear command present
- `clr_idx`  in  log_width  slot to mark free
- `clr_ready`  out  1  clear channel can accept
- `bitmap`  out  width  registered occupancy vector; bit i = slot i occupied
- `count`  out  log_width+1  registered popcount of `bitmap`
- `full`  out  1  `count == width`
- `empty`  out  1  `count == 0`
- `err_dup_set`  out  1  one-cycle pulse: accepted set hit an occupied slot
- `err_bad_clr`  out  1  one-cycle pulse: accepted clear hit a free slot
- `err_range`  out  1  one-cycle pulse: accepted command with idx >= width

## Operation
- A set fires when `set_valid && set_ready`. A clear fires when `clr_valid && clr_ready`. Both may fire in the same cycle.
- `set_ready = !full` and `clr_ready = !empty`. Both are derived from registered state only, with no combinational path from the valids.
- Each fired index is decoded to a one-hot mask of width bits. An index >= width produces an all-zero mask, pulses `err_range`, and has no effect on the bitmap.
- Update order within one cycle, evaluated against the current `bitmap`:
  - The clear applies first. If the target bit is 1, it is cleared. If it is 0, `err_bad_clr` pulses and there is no change.
  - The set then applies against the post-clear value. If the target bit is 0, it is set. If it is 1, `err_dup_set` pulses and there is no change.
- The same index on both channels:
  - Bit was 1: it ends at 1, no error pulses, and `count` is unchanged.
  - Bit was 0: `err_bad_clr` pulses, the bit ends at 1, and `count` is +1.
- Different indices on both channels are applied independently. `count` changes by (sets applied) minus (clears applied), a net change in {-1, 0, +1}.
- `count` is maintained incrementally, not recomputed. It must always equal popcount(`bitmap`) and must never wrap.
- Errored commands are still consumed: ready was high, so the handshake completes.

## Timing
- Reset values: `bitmap`=0, `count`=0, `empty`=1, `full`=0, all `err_*`=0, `set_ready`=1, `clr_ready`=0.
- `rst` overrides any command fired in the same cycle; the state returns to the reset values next cycle.
- Latency is one cycle. A command fired at edge N is visible on `bitmap`, `count`, `full`, `empty` and `err_*` after edge N (cycle N+1).
- Error pulses last exactly one cycle per offending command. Back-to-back offending commands give back-to-back pulses.
- Readiness when full:
  - While `full`, `set_ready`=0 even if a clear fires that same cycle.
  - After the clear lands (next cycle), `set_ready` returns to 1.
- Readiness when empty: while `empty`, `clr_ready`=0. A set fired into an empty bitmap enables clears from the next cycle.
- There is no internal stall, so throughput is one set plus one clear per cycle.

## Test plan
- Reset, then set idx 5:
  - Next cycle: `bitmap`=0x0000_0020, `count`=1, `empty`=0.
  - `clr_ready` rises in that same cycle.
- Fill sequence:
  - Set idx 0..31 on consecutive cycles. After the last: `bitmap`=0xFFFF_FFFF, `count`=32, `full`=1, `set_ready`=0.
  - Hold `set_valid`=1 with idx 3: no accept, no state change.
- Concurrent ops, starting from bitmap 0x0000_0009:
  - Set 7 and clear 0 together: `bitmap`=0x0000_0088, `count`=2.
  - Then set 7 and clear 7 together: `bitmap` stays 0x0000_0088, no errors.
- Errors, starting from bitmap 0x0000_0088:
  - Set 3: `err_dup_set`=1 for one cycle, bitmap unchanged.
  - Clear 4: `err_bad_clr`=1 for one cycle, bitmap unchanged.
  - With width=20, log_width=5: set idx 25 gives `err_range`=1 and no change.
- Full-boundary clear-then-set:
  - At full, clear 9: next cycle `full`=0, `set_ready`=1, `count`=31.
  - Then set 9: `full`=1 again.
- Reset mid-operation: with the bitmap at 0xF0F0 and set/clear both firing, assert `rst` → next cycle all outputs are at their reset values; the fired commands are lost.
